cmp_reservation_station: RTL and testbench
==========================================

# cmp_reservation_station

Reservation station for the compare execution unit. It holds up to DEPTH dispatched compare instructions and captures pending GPR operands by snooping the common data bus (CDB). Each cycle it issues the oldest entry whose operands are both resolved to the compare unit over a valid/ready handshake. Slot index i is tagged with rs_id = RS_BASE_ID + i, which is the tag the CR writeback carries.

## Interface
- RS_ID_WIDTH, 5, width of every producer tag and of rs_id
- DEPTH, 4, number of entries (2..8)
- RS_BASE_ID, 0, tag of slot 0; slots use RS_BASE_ID..RS_BASE_ID+DEPTH-1 (must fit in RS_ID_WIDTH)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard all entries (mispredict)
- disp_valid / disp_ready  in / out  1 / 1  dispatch handshake
- disp_op1, disp_op2  in  32 each  operand values, used when the matching `_rdy` is 1
- disp_op1_rdy, disp_op2_rdy  in  1 each  operand already resolved
- disp_op1_tag, disp_op2_tag  in  RS_ID_WIDTH each  producer tag, used when the matching `_rdy` is 0
- disp_xer_so  in  1  resolved XER[SO]
- disp_control  in  cmp_decode_t  carried opaquely
- disp_cr_addr  in  3  destination CR field
- cdb_valid  in  1  CDB result valid
- cdb_rs_id  in  RS_ID_WIDTH  CDB producer tag
- cdb_data  in  32  CDB result value
- issue_valid / issue_ready  out / in  1 / 1  issue handshake to the compare unit
- issue_rs_id  out  RS_ID_WIDTH  tag of the issuing slot
- issue_op1, issue_op2  out  32 each  issued operand values
- issue_xer_so  out  1  issued XER[SO]
- issue_control  out  cmp_decode_t  issued control
- issue_cr_addr  out  3  issued destination CR field
- occupancy  out  $clog2(DEPTH+1)  number of valid entries

## Operation
- Per-slot state:
  - valid bit
  - for each operand: value, tag and rdy bit
  - xer_so, control, cr_addr
  - age row older[i][*]
- Allocation:
  - A dispatch is accepted when disp_valid && disp_ready.
  - The entry is written into the lowest-index free slot.
  - That slot's age row marks it younger than every currently valid slot.
- disp_ready = !rst && !flush && (at least one slot is invalid at the start of the cycle).
  - A slot freed by issue in the same cycle is not counted as free.
- Dispatch bypass:
  - Condition: an operand arrives with rdy=0 and cdb_valid=1 in the same cycle, and cdb_rs_id == that operand's tag.
  - The slot stores cdb_data with rdy=1.
- Wakeup:
  - Condition: cdb_valid=1 and a valid slot's operand has rdy=0 and a tag equal to cdb_rs_id.
  - That operand latches cdb_data and sets rdy=1.
  - Both operands of one slot, and any number of slots, may wake on the same CDB beat.
- Eligibility: a slot is eligible when it is valid and both of its rdy bits are 1.
- Selection: select the eligible slot for which no other eligible slot is older.
  - The age matrix guarantees uniqueness.
- issue_valid = (any slot eligible) && !flush && !rst.
  - The issue_* outputs are driven combinationally from the selected slot.
  - When issue_valid is 0, the issue_* outputs are 0.
- Issue:
  - On issue_valid && issue_ready, the selected slot's valid bit clears at the clock edge.
  - Its age column is cleared.
- Flush: all valid bits clear at the edge. Flush beats dispatch and issue in the same cycle; neither takes effect.
- occupancy = popcount(valid), registered from state.

## Timing
- Reset values:
  - all valid bits 0
  - occupancy 0
  - issue_valid 0, all issue_* outputs 0
  - disp_ready 0 while rst is high, 1 in the first cycle after rst deasserts
- Dispatch with both operands ready in cycle N: the entry is eligible in cycle N+1, so issue_valid can be 1 in N+1 (minimum latency 1).
- CDB wakeup in cycle N: the operand is eligible in cycle N+1. CDB data never feeds issue combinationally in the same cycle.
- Issue stall: while issue_ready is 0, the issue_* outputs hold the same oldest eligible slot. A younger slot cannot preempt it.
  - The selection can change only if an older slot becomes eligible via wakeup.
- Full:
  - With occupancy == DEPTH, disp_ready is 0, including in a cycle where issue fires.
  - In the next cycle disp_ready is 1.
- Simultaneous dispatch, issue and CDB beat: all three take effect. The new slot is younger than all survivors.
- A CDB tag that matches no pending operand is ignored.
- CDB data for an operand whose rdy bit is already 1 must not overwrite its value.
- rst asserted mid-operation: all entries are lost at the next edge, regardless of any handshake.

## Test plan
- Reset, then dispatch one entry with op1=5, op2=7, both rdy, cr_addr=3, issue_ready=1 -> in the next cycle issue_valid=1, issue_rs_id=RS_BASE_ID, issue_op1=5, issue_op2=7, issue_cr_addr=3; after that occupancy=0.
- Dispatch A (op1 tag 9, not ready), then B (both ready) -> B issues first. Then CDB beat tag 9 with data 0xFFFFFFFF -> A issues one cycle later with issue_op1=0xFFFFFFFF.
- Fill DEPTH=4 entries with issue_ready=0 -> disp_ready=0 and occupancy=4. Raise issue_ready for one cycle -> the oldest entry issues, disp_ready stays 0 in that cycle and becomes 1 in the next.
- Dispatch with op1 and op2 both tag 12, not ready, in the same cycle as a CDB beat with tag 12 and data 0x80000000 -> the entry issues in the next cycle with both operands equal to 0x80000000.
- With 3 entries valid, assert flush together with disp_valid -> the dispatch is not accepted, issue_valid=0, occupancy=0 in the next cycle. Assert rst while 2 entries are pending -> all outputs return to their reset values.
- Two entries become eligible on the same CDB beat -> the older one issues first and the younger one issues in the following cycle with issue_ready held at 1.

Source files
------------

// File: rtl/cmp_reservation_station_if.sv
//------------------------------------------------------------------------------
// cmp_rs_pkg / cmp_rs_if: compare-op decode type and reservation station bundle
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cmp_rs_pkg;
  typedef struct packed {
    logic is_unsigned;
    logic is_64;
    logic use_imm;
  } cmp_decode_t;
endpackage

interface cmp_rs_if #(
  parameter int RS_ID_WIDTH = 5,
  parameter int DEPTH       = 4
);
  logic                       flush;
  logic                       disp_valid;
  logic                       disp_ready;
  logic [31:0]                disp_op1;
  logic [31:0]                disp_op2;
  logic                       disp_op1_rdy;
  logic                       disp_op2_rdy;
  logic [RS_ID_WIDTH-1:0]     disp_op1_tag;
  logic [RS_ID_WIDTH-1:0]     disp_op2_tag;
  logic                       disp_xer_so;
  cmp_rs_pkg::cmp_decode_t    disp_control;
  logic [2:0]                 disp_cr_addr;
  logic                       cdb_valid;
  logic [RS_ID_WIDTH-1:0]     cdb_rs_id;
  logic [31:0]                cdb_data;
  logic                       issue_valid;
  logic                       issue_ready;
  logic [RS_ID_WIDTH-1:0]     issue_rs_id;
  logic [31:0]                issue_op1;
  logic [31:0]                issue_op2;
  logic                       issue_xer_so;
  cmp_rs_pkg::cmp_decode_t    issue_control;
  logic [2:0]                 issue_cr_addr;
  logic [$clog2(DEPTH+1)-1:0] occupancy;

  modport master (
    output flush, disp_valid, disp_op1, disp_op2, disp_op1_rdy, disp_op2_rdy,
           disp_op1_tag, disp_op2_tag, disp_xer_so, disp_control, disp_cr_addr,
           cdb_valid, cdb_rs_id, cdb_data, issue_ready,
    input  disp_ready, issue_valid, issue_rs_id, issue_op1, issue_op2,
           issue_xer_so, issue_control, issue_cr_addr, occupancy
  );

  modport slave (
    input  flush, disp_valid, disp_op1, disp_op2, disp_op1_rdy, disp_op2_rdy,
           disp_op1_tag, disp_op2_tag, disp_xer_so, disp_control, disp_cr_addr,
           cdb_valid, cdb_rs_id, cdb_data, issue_ready,
    output disp_ready, issue_valid, issue_rs_id, issue_op1, issue_op2,
           issue_xer_so, issue_control, issue_cr_addr, occupancy
  );
endinterface

`default_nettype wire

// File: rtl/cmp_reservation_station.sv
//------------------------------------------------------------------------------
// cmp_reservation_station: age-ordered compare-unit reservation station, CDB wakeup
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cmp_reservation_station #(
  parameter int RS_ID_WIDTH = 5,
  parameter int DEPTH       = 4,
  parameter int RS_BASE_ID  = 0
) (
  input  wire logic clk,
  input  wire logic rst,
  cmp_rs_if.slave   io_rs
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]          r_valid;
  logic [DEPTH-1:0]          r_older   [DEPTH];
  logic [31:0]               r_op1     [DEPTH];
  logic [31:0]               r_op2     [DEPTH];
  logic [RS_ID_WIDTH-1:0]    r_tag1    [DEPTH];
  logic [RS_ID_WIDTH-1:0]    r_tag2    [DEPTH];
  logic [DEPTH-1:0]          r_rdy1;
  logic [DEPTH-1:0]          r_rdy2;
  logic [DEPTH-1:0]          r_xer_so;
  cmp_rs_pkg::cmp_decode_t   r_ctrl    [DEPTH];
  logic [2:0]                r_cr_addr [DEPTH];

  logic [DEPTH-1:0]          w_elig;
  logic [IDX_W-1:0]          w_sel_idx;
  logic [IDX_W-1:0]          w_free_idx;
  logic [DEPTH-1:0]          w_issue_mask;
  logic [CNT_W-1:0]          w_occ;
  logic                      w_any_free;
  logic                      w_disp_fire;
  logic                      w_issue_fire;
  logic                      w_byp1;
  logic                      w_byp2;

  assign w_elig     = r_valid & r_rdy1 & r_rdy2;
  assign w_any_free = ~(&r_valid);

  // r_older[i][j] set means slot j is older than slot i; the oldest eligible slot
  // is the one whose row has no bit set among the eligible slots.
  always_comb begin
    w_sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_elig[i] && ((r_older[i] & w_elig) == '0)) begin
        w_sel_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_free_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_occ = w_occ + CNT_W'(r_valid[i]);
    end
  end

  assign io_rs.disp_ready  = !rst && !io_rs.flush && w_any_free;
  assign io_rs.issue_valid = (|w_elig) && !io_rs.flush && !rst;
  assign io_rs.occupancy   = w_occ;

  assign w_disp_fire  = io_rs.disp_valid && io_rs.disp_ready;
  assign w_issue_fire = io_rs.issue_valid && io_rs.issue_ready;
  assign w_issue_mask = w_issue_fire ? (DEPTH'(1) << w_sel_idx) : '0;

  assign w_byp1 = io_rs.cdb_valid && !io_rs.disp_op1_rdy && (io_rs.disp_op1_tag == io_rs.cdb_rs_id);
  assign w_byp2 = io_rs.cdb_valid && !io_rs.disp_op2_rdy && (io_rs.disp_op2_tag == io_rs.cdb_rs_id);

  always_comb begin
    io_rs.issue_rs_id   = '0;
    io_rs.issue_op1     = '0;
    io_rs.issue_op2     = '0;
    io_rs.issue_xer_so  = 1'b0;
    io_rs.issue_control = '0;
    io_rs.issue_cr_addr = '0;
    if (io_rs.issue_valid) begin
      io_rs.issue_rs_id   = RS_ID_WIDTH'(RS_BASE_ID) + RS_ID_WIDTH'(w_sel_idx);
      io_rs.issue_op1     = r_op1[w_sel_idx];
      io_rs.issue_op2     = r_op2[w_sel_idx];
      io_rs.issue_xer_so  = r_xer_so[w_sel_idx];
      io_rs.issue_control = r_ctrl[w_sel_idx];
      io_rs.issue_cr_addr = r_cr_addr[w_sel_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || io_rs.flush) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_older[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_valid[i] && io_rs.cdb_valid) begin
          if (!r_rdy1[i] && (r_tag1[i] == io_rs.cdb_rs_id)) begin
            r_op1[i]  <= io_rs.cdb_data;
            r_rdy1[i] <= 1'b1;
          end
          if (!r_rdy2[i] && (r_tag2[i] == io_rs.cdb_rs_id)) begin
            r_op2[i]  <= io_rs.cdb_data;
            r_rdy2[i] <= 1'b1;
          end
        end
      end

      if (w_issue_fire) begin
        r_valid[w_sel_idx] <= 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
          r_older[i][w_sel_idx] <= 1'b0;
        end
      end

      // The new row excludes the issuing slot, so this later write to the same
      // row keeps the column clear above consistent.
      if (w_disp_fire) begin
        r_valid[w_free_idx]   <= 1'b1;
        r_older[w_free_idx]   <= r_valid & ~w_issue_mask;
        r_op1[w_free_idx]     <= w_byp1 ? io_rs.cdb_data : io_rs.disp_op1;
        r_op2[w_free_idx]     <= w_byp2 ? io_rs.cdb_data : io_rs.disp_op2;
        r_rdy1[w_free_idx]    <= io_rs.disp_op1_rdy | w_byp1;
        r_rdy2[w_free_idx]    <= io_rs.disp_op2_rdy | w_byp2;
        r_tag1[w_free_idx]    <= io_rs.disp_op1_tag;
        r_tag2[w_free_idx]    <= io_rs.disp_op2_tag;
        r_xer_so[w_free_idx]  <= io_rs.disp_xer_so;
        r_ctrl[w_free_idx]    <= io_rs.disp_control;
        r_cr_addr[w_free_idx] <= io_rs.disp_cr_addr;
      end
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_cmp_reservation_station.sv
//------------------------------------------------------------------------------
// tb_cmp_reservation_station: directed stimulus with a scoreboard on the issue port
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_cmp_reservation_station;
  localparam int IDW  = 5;
  localparam int DEP  = 4;
  localparam int BASE = 16;

  typedef struct {
    logic [IDW-1:0] id;
    logic [31:0]    op1;
    logic [31:0]    op2;
    logic [2:0]     cr;
    logic           xer;
    logic [2:0]     ctrl;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_pass  = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  cmp_rs_if #(.RS_ID_WIDTH(IDW), .DEPTH(DEP)) rs ();

  cmp_reservation_station #(
    .RS_ID_WIDTH (IDW),
    .DEPTH       (DEP),
    .RS_BASE_ID  (BASE)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .io_rs (rs)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic push(input int slot, input logic [31:0] op1, input logic [31:0] op2,
                      input logic [2:0] cr, input logic xer, input logic [2:0] ctrl);
    exp_t e;
    e.id = IDW'(BASE + slot); e.op1 = op1; e.op2 = op2; e.cr = cr; e.xer = xer; e.ctrl = ctrl;
    exp_q.push_back(e);
  endtask

  task automatic disp(input logic [31:0] op1, input logic rdy1, input logic [IDW-1:0] tag1,
                      input logic [31:0] op2, input logic rdy2, input logic [IDW-1:0] tag2,
                      input logic [2:0] cr, input logic xer, input logic [2:0] ctrl);
    rs.disp_valid   = 1'b1;
    rs.disp_op1     = op1;  rs.disp_op1_rdy = rdy1; rs.disp_op1_tag = tag1;
    rs.disp_op2     = op2;  rs.disp_op2_rdy = rdy2; rs.disp_op2_tag = tag2;
    rs.disp_cr_addr = cr;   rs.disp_xer_so  = xer;
    rs.disp_control = cmp_rs_pkg::cmp_decode_t'(ctrl);
  endtask

  task automatic cdb(input logic [IDW-1:0] tag, input logic [31:0] data);
    rs.cdb_valid = 1'b1; rs.cdb_rs_id = tag; rs.cdb_data = data;
  endtask

  task automatic quiet();
    rs.disp_valid = 1'b0; rs.cdb_valid = 1'b0; rs.flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Issue-port monitor: every accepted issue must match the next scoreboard entry.
  always @(negedge clk) begin
    if (!rst && rs.issue_valid && rs.issue_ready) begin
      if (exp_q.size() == 0) begin
        check("issue_unexpected", 64'(rs.issue_rs_id), 64'hFFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("issue_rs_id",  64'(rs.issue_rs_id),   64'(mon_e.id));
        check("issue_op1",    64'(rs.issue_op1),     64'(mon_e.op1));
        check("issue_op2",    64'(rs.issue_op2),     64'(mon_e.op2));
        check("issue_cr",     64'(rs.issue_cr_addr), 64'(mon_e.cr));
        check("issue_xer_so", 64'(rs.issue_xer_so),  64'(mon_e.xer));
        check("issue_ctrl",   64'(rs.issue_control), 64'(mon_e.ctrl));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rs.flush = 1'b0; rs.disp_valid = 1'b0; rs.disp_op1 = '0; rs.disp_op2 = '0;
    rs.disp_op1_rdy = 1'b0; rs.disp_op2_rdy = 1'b0; rs.disp_op1_tag = '0; rs.disp_op2_tag = '0;
    rs.disp_xer_so = 1'b0; rs.disp_control = '0; rs.disp_cr_addr = '0;
    rs.cdb_valid = 1'b0; rs.cdb_rs_id = '0; rs.cdb_data = '0; rs.issue_ready = 1'b0;

    // Reset behaviour
    tick(); tick();
    @(negedge clk);
    check("rst_disp_ready", 64'(rs.disp_ready), 64'd0);
    check("rst_issue_valid", 64'(rs.issue_valid), 64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_disp_ready", 64'(rs.disp_ready), 64'd1);
    check("post_rst_occupancy", 64'(rs.occupancy), 64'd0);
    check("post_rst_issue_valid", 64'(rs.issue_valid), 64'd0);
    check("post_rst_issue_op1", 64'(rs.issue_op1), 64'd0);
    tick();

    // Single entry, minimum latency
    rs.issue_ready = 1'b1;
    disp(32'd5, 1, 0, 32'd7, 1, 0, 3'd3, 1'b1, 3'b101);
    push(0, 32'd5, 32'd7, 3'd3, 1'b1, 3'b101);
    @(negedge clk);
    check("t1_disp_ready", 64'(rs.disp_ready), 64'd1);
    tick(); quiet();
    @(negedge clk);
    check("t1_issue_valid_n1", 64'(rs.issue_valid), 64'd1);
    tick();
    @(negedge clk);
    check("t1_occupancy", 64'(rs.occupancy), 64'd0);

    // Younger ready entry overtakes older pending one; CDB wakeup
    tick();
    disp(32'd0, 0, 5'd9, 32'd2, 1, 0, 3'd1, 1'b0, 3'b001);
    tick();
    disp(32'h11, 1, 0, 32'h22, 1, 0, 3'd2, 1'b0, 3'b010);
    push(1, 32'h11, 32'h22, 3'd2, 1'b0, 3'b010);
    tick(); quiet();
    @(negedge clk);
    check("t2_b_issue_valid", 64'(rs.issue_valid), 64'd1);
    tick();
    cdb(5'd9, 32'hFFFF_FFFF);
    push(0, 32'hFFFF_FFFF, 32'd2, 3'd1, 1'b0, 3'b001);
    @(negedge clk);
    check("t2_cdb_no_comb_issue", 64'(rs.issue_valid), 64'd0);
    check("t2_occupancy", 64'(rs.occupancy), 64'd1);
    tick(); quiet();
    @(negedge clk);
    check("t2_a_issue_valid", 64'(rs.issue_valid), 64'd1);
    tick();
    @(negedge clk);
    check("t2_occupancy_end", 64'(rs.occupancy), 64'd0);

    // Fill to full under stall; stray CDB must not touch resolved operands
    tick();
    rs.issue_ready = 1'b0;
    for (int k = 0; k < DEP; k++) begin
      disp(32'h100 + 32'(k), 1, 5'd5, 32'h200 + 32'(k), 1, 5'd5, 3'(k), k[0], 3'(k + 1));
      if (k == DEP - 1) cdb(5'd5, 32'hDEAD_BEEF);
      tick();
    end
    quiet();
    @(negedge clk);
    check("t3_full_disp_ready", 64'(rs.disp_ready), 64'd0);
    check("t3_full_occupancy", 64'(rs.occupancy), 64'd4);
    check("t3_stall_rs_id", 64'(rs.issue_rs_id), 64'(BASE));
    tick();
    rs.issue_ready = 1'b1;
    push(0, 32'h100, 32'h200, 3'd0, 1'b0, 3'd1);
    @(negedge clk);
    check("t3_issue_cycle_disp_ready", 64'(rs.disp_ready), 64'd0);
    tick();
    rs.issue_ready = 1'b0;
    @(negedge clk);
    check("t3_after_issue_disp_ready", 64'(rs.disp_ready), 64'd1);
    check("t3_after_issue_occupancy", 64'(rs.occupancy), 64'd3);
    check("t3_next_oldest_rs_id", 64'(rs.issue_rs_id), 64'(BASE + 1));
    tick();
    rs.issue_ready = 1'b1;
    for (int k = 1; k < DEP; k++) push(k, 32'h100 + 32'(k), 32'h200 + 32'(k), 3'(k), k[0], 3'(k + 1));
    tick(); tick(); tick();
    @(negedge clk);
    check("t3_drained_occupancy", 64'(rs.occupancy), 64'd0);

    // Dispatch bypass of both operands
    tick();
    disp(32'd0, 0, 5'd12, 32'd0, 0, 5'd12, 3'd5, 1'b1, 3'b110);
    cdb(5'd12, 32'h8000_0000);
    push(0, 32'h8000_0000, 32'h8000_0000, 3'd5, 1'b1, 3'b110);
    tick(); quiet();
    @(negedge clk);
    check("t4_bypass_issue_valid", 64'(rs.issue_valid), 64'd1);
    tick();

    // Flush beats dispatch
    rs.issue_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      disp(32'(k), 1, 0, 32'(k), 1, 0, 3'd0, 1'b0, 3'd0);
      tick();
    end
    disp(32'h77, 1, 0, 32'h77, 1, 0, 3'd0, 1'b0, 3'd0);
    rs.flush = 1'b1;
    @(negedge clk);
    check("t5_flush_disp_ready", 64'(rs.disp_ready), 64'd0);
    check("t5_flush_issue_valid", 64'(rs.issue_valid), 64'd0);
    tick(); quiet();
    @(negedge clk);
    check("t5_post_flush_issue_valid", 64'(rs.issue_valid), 64'd0);
    check("t5_post_flush_occupancy", 64'(rs.occupancy), 64'd0);

    // Reset mid-operation
    tick();
    disp(32'h1, 1, 0, 32'h2, 1, 0, 3'd1, 1'b0, 3'd0);
    tick();
    disp(32'h3, 1, 0, 32'h4, 1, 0, 3'd2, 1'b0, 3'd0);
    tick();
    rst = 1'b1; rs.issue_ready = 1'b1;
    @(negedge clk);
    check("t5_rst_disp_ready", 64'(rs.disp_ready), 64'd0);
    check("t5_rst_issue_valid", 64'(rs.issue_valid), 64'd0);
    tick();
    rst = 1'b0; quiet(); rs.issue_ready = 1'b0;
    @(negedge clk);
    check("t5_rst_occupancy", 64'(rs.occupancy), 64'd0);
    check("t5_rst_issue_rs_id", 64'(rs.issue_rs_id), 64'd0);
    check("t5_rst_issue_op1", 64'(rs.issue_op1), 64'd0);
    check("t5_rst_ready_again", 64'(rs.disp_ready), 64'd1);

    // Two slots wake on the same beat
    tick();
    disp(32'd0, 0, 5'd7, 32'd1, 1, 0, 3'd4, 1'b0, 3'b011);
    tick();
    disp(32'd3, 1, 0, 32'd0, 0, 5'd7, 3'd6, 1'b1, 3'b100);
    tick(); quiet();
    cdb(5'd7, 32'hA5A5_A5A5);
    rs.issue_ready = 1'b1;
    push(0, 32'hA5A5_A5A5, 32'd1, 3'd4, 1'b0, 3'b011);
    push(1, 32'd3, 32'hA5A5_A5A5, 3'd6, 1'b1, 3'b100);
    tick(); quiet();
    @(negedge clk);
    check("t6_older_first", 64'(rs.issue_rs_id), 64'(BASE));
    tick();
    @(negedge clk);
    check("t6_younger_next", 64'(rs.issue_rs_id), 64'(BASE + 1));
    tick();

    // Dispatch, issue and CDB wakeup in one cycle
    rs.issue_ready = 1'b0;
    disp(32'd0, 0, 5'd3, 32'h30, 1, 0, 3'd1, 1'b0, 3'b001);
    tick();
    disp(32'h40, 1, 0, 32'h41, 1, 0, 3'd2, 1'b1, 3'b010);
    tick();
    rs.issue_ready = 1'b1;
    disp(32'h50, 1, 0, 32'h51, 1, 0, 3'd7, 1'b0, 3'b111);
    cdb(5'd3, 32'h33);
    push(1, 32'h40, 32'h41, 3'd2, 1'b1, 3'b010);
    push(0, 32'h33, 32'h30, 3'd1, 1'b0, 3'b001);
    push(2, 32'h50, 32'h51, 3'd7, 1'b0, 3'b111);
    @(negedge clk);
    check("t7_triple_disp_ready", 64'(rs.disp_ready), 64'd1);
    tick(); quiet();
    tick(); tick();
    @(negedge clk);
    check("t7_occupancy", 64'(rs.occupancy), 64'd0);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

`default_nettype wire
